// File: rtl/median_pkg.sv
// Shared types and constants for the median window feeder and the
// 3-input median stage that consumes its windows.
package median_pkg;

    // Default frame length, also the median stage's loop bound.
    localparam int FRAME_LEN_DEFAULT = 8533;
    localparam int SAMPLE_W          = 32;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // One window as seen by the median stage, oldest sample first.
    typedef struct packed {
        sample_t word0;
        sample_t word1;
        sample_t word2;
    } window_t;

    // FILL gathers the first samples of a frame, STREAM emits one window per
    // accepted sample, DRAIN emits the replicated tail window (edge
    // replication builds only).
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/median_out_reg.sv
// Output holding register for one window with valid/ready.
// A load always wins; otherwise a completed transfer empties the register.
// The words keep their last value after a transfer; only valid/last clear.
module median_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word0,
    input  logic [WIDTH-1:0] load_word1,
    input  logic [WIDTH-1:0] load_word2,
    input  logic             load_last,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_word0,
    output logic [WIDTH-1:0] out_word1,
    output logic [WIDTH-1:0] out_word2,
    output logic             out_last
);

    // Hold the presented window until it is taken or replaced.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_word0 <= '0;
            out_word1 <= '0;
            out_word2 <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_last  <= load_last;
            out_word0 <= load_word0;
            out_word1 <= load_word1;
            out_word2 <= load_word2;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/median_window_stream.sv
// Sliding 3-sample window feeder for the median stage.
// Samples arrive with valid/ready; each frame of FRAME_LEN samples yields
// FRAME_LEN-2 windows (oldest..newest), the last one flagged with out_last.
// Windows never straddle a frame boundary.
// Optional: define MEDIAN_WINDOW_EDGE_REPLICATE_EN to pad both frame edges
// by replication, giving FRAME_LEN windows per frame via a DRAIN state.
module median_window_stream
    import median_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
    parameter int FCNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_word0,
    output logic [WIDTH-1:0]  out_word1,
    output logic [WIDTH-1:0]  out_word2,
    output logic              out_last,
    output logic [FCNT_W-1:0] frames_done
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
`ifdef MEDIAN_WINDOW_EDGE_REPLICATE_EN
    // The first padded window {x0,x0,x1} is complete once x1 arrives.
    localparam logic [CNT_W-1:0] FIRST_IDX = CNT_W'(1);
`else
    // The first window {x0,x1,x2} is complete once x2 arrives.
    localparam logic [CNT_W-1:0] FIRST_IDX = CNT_W'(2);
`endif

    state_t           state;
    logic [CNT_W-1:0] count;   // index of the next sample within the frame
    // Only the two most recent samples are stored: a new window is assembled
    // from them plus the incoming sample, so the oldest slot would be dead.
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    logic             accept;
    logic             out_free;
    logic             fill_done;
    logic             at_last;
    logic             load;
    logic             load_last;
    logic [WIDTH-1:0] load_word0;
    logic [WIDTH-1:0] load_word1;
    logic [WIDTH-1:0] load_word2;

    assign accept    = in_valid & in_ready;
    assign out_free  = !out_valid | out_ready;
    assign fill_done = (count == FIRST_IDX);
    assign at_last   = (count == LAST_IDX);

    // Backpressure: a sample that produces a window needs the output register free.
    always_comb begin
        // NOTE: default first so no path through this block infers a latch.
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                FILL:    in_ready = !fill_done | out_free;
                STREAM:  in_ready = out_free;
                default: in_ready = 1'b0;
            endcase
        end
    end

    // Select the window to load and when to load it.
    always_comb begin
        load       = 1'b0;
        load_last  = at_last;
        load_word0 = s1;
        load_word1 = s2;
        load_word2 = in_data;
        case (state)
            FILL: begin
                load = accept & fill_done;
`ifdef MEDIAN_WINDOW_EDGE_REPLICATE_EN
                load_word0 = s2;
                load_last  = 1'b0;
`endif
            end
            STREAM: begin
                load = accept;
`ifdef MEDIAN_WINDOW_EDGE_REPLICATE_EN
                load_last = 1'b0;
`endif
            end
            DRAIN: begin
                load       = out_free;
                load_word0 = s1;
                load_word1 = s2;
                load_word2 = s2;
                load_last  = 1'b1;
            end
            default: load = 1'b0;
        endcase
    end

    // Shift register, in-frame sample counter, frame FSM and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            count       <= '0;
            s1          <= '0;
            s2          <= '0;
            frames_done <= '0;
        end else begin
            if (accept) begin
                s1    <= s2;
                s2    <= in_data;
                count <= at_last ? '0 : count + 1'b1;
            end

            case (state)
                FILL: begin
                    if (accept && fill_done && !at_last)
                        state <= STREAM;
                end
                STREAM: begin
                    if (accept && at_last)
`ifdef MEDIAN_WINDOW_EDGE_REPLICATE_EN
                        state <= DRAIN;
`else
                        state <= FILL;
`endif
                end
                DRAIN: begin
                    if (out_free)
                        state <= FILL;
                end
                default: state <= FILL;
            endcase

            if (out_valid && out_ready && out_last)
                frames_done <= frames_done + 1'b1;
        end
    end

    median_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_word0(load_word0),
        .load_word1(load_word1),
        .load_word2(load_word2),
        .load_last (load_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_word0 (out_word0),
        .out_word1 (out_word1),
        .out_word2 (out_word2),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_median_window_stream.sv
// Scoreboard bench for median_window_stream (FRAME_LEN=5, FCNT_W=2).
// The driver pushes expected windows, built from the frame's sample list,
// whenever a sample is accepted; an independent monitor pops and compares
// on every output transfer.
module tb_median_window_stream;

    localparam int WIDTH     = 32;
    localparam int FRAME_LEN = 5;
    localparam int FCNT_W    = 2;

    typedef struct {
        logic [WIDTH-1:0] w0;
        logic [WIDTH-1:0] w1;
        logic [WIDTH-1:0] w2;
        logic             last;
    } win_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  out_word0;
    logic [WIDTH-1:0]  out_word1;
    logic [WIDTH-1:0]  out_word2;
    logic              out_last;
    logic [FCNT_W-1:0] frames_done;

    int n_checks = 0;
    int n_fail   = 0;

    win_t             exp_q[$];
    logic [WIDTH-1:0] cur[$];
    logic [FCNT_W-1:0] exp_fd = '0;

    always #5 clk = ~clk;

    median_window_stream #(
        .WIDTH    (WIDTH),
        .FRAME_LEN(FRAME_LEN),
        .FCNT_W   (FCNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word0  (out_word0),
        .out_word1  (out_word1),
        .out_word2  (out_word2),
        .out_last   (out_last),
        .frames_done(frames_done)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic win_t mk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] c, input logic l);
        win_t w;
        w.w0 = a; w.w1 = b; w.w2 = c; w.last = l;
        return w;
    endfunction

    // Reference model: windows that become complete with sample v.
    task automatic model_accept(input logic [WIDTH-1:0] v);
        int k;
        cur.push_back(v);
        k = cur.size() - 1;
`ifdef MEDIAN_WINDOW_EDGE_REPLICATE_EN
        if (k == 1) exp_q.push_back(mk(cur[0], cur[0], cur[1], 1'b0));
        if (k >= 2) exp_q.push_back(mk(cur[k-2], cur[k-1], cur[k], 1'b0));
        if (k == FRAME_LEN - 1) exp_q.push_back(mk(cur[k-1], cur[k], cur[k], 1'b1));
`else
        if (k >= 2) exp_q.push_back(mk(cur[k-2], cur[k-1], cur[k], k == FRAME_LEN - 1));
`endif
        if (k == FRAME_LEN - 1) cur.delete();
    endtask

    task automatic run_cycle(input logic v, input logic [WIDTH-1:0] d, input logic ordy,
                             output logic acc);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        acc = v & in_ready;
        if (acc) model_accept(d);
    endtask

    // rnd=0: always valid and ready; rnd=1: random valid and out_ready.
    task automatic send_sample(input logic [WIDTH-1:0] d, input bit rnd);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
            run_cycle(rnd ? ($urandom_range(3) != 0) : 1'b1, d,
                      rnd ? ($urandom_range(9) < 7) : 1'b1, acc);
            tries++;
        end
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        repeat (n) run_cycle(1'b0, '0, ordy, acc);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] base, input logic [WIDTH-1:0] step, input bit rnd);
        for (int i = 0; i < FRAME_LEN; i++) send_sample(base + step * i, rnd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        cur.delete();
        exp_fd = '0;
        @(negedge clk);
        #1;
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_last", out_last, 0);
        check("reset_words", {out_word0, out_word1, out_word2}, 0);
        check("reset_frames_done", frames_done, 0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", in_ready, 1);
    endtask

    // Monitor: pops the scoreboard on each output transfer, checks hold-stability
    // under backpressure and the frame counter after each last-window transfer.
    initial begin
        logic        stalled;
        logic        fd_pending;
        logic [96:0] held;
        win_t        e;
        stalled    = 1'b0;
        fd_pending = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stalled    = 1'b0;
                fd_pending = 1'b0;
            end else begin
                if (fd_pending) begin
                    check("frames_done", frames_done, exp_fd);
                    fd_pending = 1'b0;
                end
                if (stalled && out_valid)
                    check("stall_stable", {out_word0, out_word1, out_word2, out_last}, held);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_window", {out_word0, out_word1, out_word2, out_last}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("window", {out_word0, out_word1, out_word2, out_last},
                              {e.w0, e.w1, e.w2, e.last});
                        if (e.last) begin
                            exp_fd     = exp_fd + 1'b1;
                            fd_pending = 1'b1;
                        end
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = out_valid;
                    held    = {out_word0, out_word1, out_word2, out_last};
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;

        do_reset();

        // Single frame at full throughput.
        send_frame(10, 10, 1'b0);
        idle(4, 1'b1);
        check("queue_empty_t1", exp_q.size(), 0);
        check("frames_done_t1", frames_done, 1);

        // Same frame with a three-cycle stall on the second window.
        send_sample(10, 1'b0);
        send_sample(20, 1'b0);
        send_sample(30, 1'b0);
        send_sample(40, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, 50, 1'b0, acc);
            check("stall_no_accept", acc, 0);
        end
        send_sample(50, 1'b0);
        idle(4, 1'b1);
        check("queue_empty_t2", exp_q.size(), 0);

        // Two frames back to back.
        send_frame(1, 1, 1'b0);
        send_frame(6, 1, 1'b0);
        idle(4, 1'b1);
        check("queue_empty_t3", exp_q.size(), 0);

        // Abort a frame with a window still pending.
        send_frame(200, 1, 1'b0);   // completes a frame so count is aligned
        idle(4, 1'b1);
        for (int i = 0; i < 4; i++) send_sample(300 + i, 1'b0);
        idle(2, 1'b0);
        check("pending_before_reset", (exp_q.size() > 0), 1);
        do_reset();
        send_frame(100, 1, 1'b0);
        idle(4, 1'b1);
        check("queue_empty_t4", exp_q.size(), 0);

        // Four more frames: frames_done walks 1,2,3,0,1.
        for (int f = 0; f < 4; f++) send_frame(1000 + 10 * f, 1, 1'b0);
        idle(4, 1'b1);
        check("frames_done_wrap", frames_done, 1);

        // Randomised data with random valid and backpressure.
        for (int f = 0; f < 12; f++)
            for (int i = 0; i < FRAME_LEN; i++) send_sample($urandom, 1'b1);
        idle(8, 1'b1);
        check("queue_empty_rand", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
